// File: rtl/dsp_mac_pipe_if.sv
// Operand/result bundle for the dsp_mac_pipe MAC stage.
// The driver of operands uses the master modport; the MAC itself uses slave.
interface dsp_mac_pipe_if #(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int PW = 48
);
  // Operand side
  logic                CE;
  logic                IN_VALID;
  logic [AW-1:0]       A;
  logic [BW-1:0]       B;
  logic [BW-1:0]       D;
  logic [PW-1:0]       C;
  logic [PW-1:0]       PCIN;
  logic                CARRYIN;
  logic [4:0]          MODE;

  // Result side
  logic                OUT_VALID;
  logic [PW-1:0]       P;
  logic [PW-1:0]       PCOUT;
  logic [AW+BW-1:0]    M;
  logic [BW-1:0]       BCOUT;
  logic                CARRYOUT;
  logic                OVF;

  modport master (
    output CE, IN_VALID, A, B, D, C, PCIN, CARRYIN, MODE,
    input  OUT_VALID, P, PCOUT, M, BCOUT, CARRYOUT, OVF
  );

  modport slave (
    input  CE, IN_VALID, A, B, D, C, PCIN, CARRYIN, MODE,
    output OUT_VALID, P, PCOUT, M, BCOUT, CARRYOUT, OVF
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Pipelined pre-adder -> multiplier -> post-adder/accumulator MAC stage.
// The operation's MODE, CARRYIN, C and valid bit travel with the operands so
// every stage sees the controls of the operation it is processing. P only
// moves on valid results, so idle cycles never disturb an accumulation.
module dsp_mac_pipe #(
  parameter int AW        = 18,
  parameter int BW        = 18,
  parameter int PW        = 48,
  parameter int IN_STAGES = 2,
  parameter int MREG      = 1,
  parameter int SAT       = 0
) (
  input  logic           CLK,
  input  logic           RST,
  dsp_mac_pipe_if.slave  bus
);

  localparam bit SAT_EN = (SAT != 0);

  // MODE field positions
  localparam int MD_PRE_EN  = 0;
  localparam int MD_PRE_SUB = 1;
  localparam int MD_POST_SUB = 4;

  // Z multiplexer encodings (MODE[3:2])
  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_C    = 2'b01;
  localparam logic [1:0] Z_PCIN = 2'b10;
  localparam logic [1:0] Z_P    = 2'b11;

  // Everything an operation carries through the input stages.
  typedef struct packed {
    logic          valid;
    logic          cin;
    logic [4:0]    mode;
    logic [PW-1:0] c;
    logic [BW-1:0] d;
    logic [BW-1:0] b;
    logic [AW-1:0] a;
  } in_word_t;

  // Everything an operation carries from the multiplier to the post-adder.
  typedef struct packed {
    logic             valid;
    logic             cin;
    logic [4:0]       mode;
    logic [PW-1:0]    c;
    logic [AW+BW-1:0] m;
  } m_word_t;

  in_word_t          w_in_raw;
  in_word_t          w_in_stg;
  logic [BW-1:0]     w_x;
  logic [AW+BW-1:0]  w_m_raw;
  m_word_t           w_m_raw_word;
  m_word_t           w_m_stg;
  logic [PW-1:0]     w_z;
  logic [PW:0]       w_madd;
  logic [PW:0]       w_s;
  logic [PW-1:0]     w_p_next;
  logic              w_ovf_next;

  logic [PW-1:0]     r_p;
  logic              r_carryout;
  logic              r_ovf;
  logic              r_out_valid;

  assign w_in_raw = '{
    valid: bus.IN_VALID,
    cin:   bus.CARRYIN,
    mode:  bus.MODE,
    c:     bus.C,
    d:     bus.D,
    b:     bus.B,
    a:     bus.A
  };

  // ---------------------------------------------------------------------------
  // Input stages: 0, 1 or 2 register slices on the whole operation word.
  // ---------------------------------------------------------------------------
  generate
    if (IN_STAGES == 0) begin : g_in_comb
      assign w_in_stg = w_in_raw;
    end else begin : g_in_regs
      in_word_t r_stg [IN_STAGES];

      // Shift the operation word down the input slices on each enabled clock.
      always_ff @(posedge CLK) begin
        if (RST) begin
          // NOTE: the data slices are cleared too, not just the valid bits,
          // because a reset must leave every register of the slice at zero.
          for (int i = 0; i < IN_STAGES; i++) r_stg[i] <= '0;
        end else if (bus.CE) begin
          // NOTE: non-blocking assignments let every slice sample the value its
          // predecessor held before this edge, independent of statement order.
          r_stg[0] <= w_in_raw;
          for (int i = 1; i < IN_STAGES; i++) r_stg[i] <= r_stg[i-1];
        end
      end

      assign w_in_stg = r_stg[IN_STAGES-1];
    end
  endgenerate

  assign bus.BCOUT = w_in_stg.b;

  // ---------------------------------------------------------------------------
  // Pre-adder and multiplier.
  // ---------------------------------------------------------------------------

  // Select B, D+B or D-B as the multiplier's second operand (modulo 2^BW).
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    w_x = w_in_stg.b;
    if (w_in_stg.mode[MD_PRE_EN]) begin
      if (w_in_stg.mode[MD_PRE_SUB]) w_x = w_in_stg.d - w_in_stg.b;
      else                           w_x = w_in_stg.d + w_in_stg.b;
    end
  end

  // Both operands are widened to the full product width so the result is exact.
  assign w_m_raw = {{BW{1'b0}}, w_in_stg.a} * {{AW{1'b0}}, w_x};

  assign w_m_raw_word = '{
    valid: w_in_stg.valid,
    cin:   w_in_stg.cin,
    mode:  w_in_stg.mode,
    c:     w_in_stg.c,
    m:     w_m_raw
  };

  generate
    if (MREG == 0) begin : g_m_comb
      assign w_m_stg = w_m_raw_word;
    end else begin : g_m_reg
      m_word_t r_m_stg;

      // Register the product together with the controls of its operation.
      always_ff @(posedge CLK) begin
        if (RST)         r_m_stg <= '0;
        else if (bus.CE) r_m_stg <= w_m_raw_word;
      end

      assign w_m_stg = r_m_stg;
    end
  endgenerate

  assign bus.M = w_m_stg.m;

  // ---------------------------------------------------------------------------
  // Post-adder, saturation and result register.
  // ---------------------------------------------------------------------------

  // Z source chosen by the operation now at the post-adder; PCIN is live.
  always_comb begin
    w_z = '0;
    case (w_m_stg.mode[3:2])
      Z_ZERO:  w_z = '0;
      Z_C:     w_z = w_m_stg.c;
      Z_PCIN:  w_z = bus.PCIN;
      Z_P:     w_z = r_p;
      default: w_z = '0;
    endcase
  end

  // M plus carry always fits in PW bits because PW >= AW+BW+1.
  assign w_madd = {{(PW+1-AW-BW){1'b0}}, w_m_stg.m} + {{PW{1'b0}}, w_m_stg.cin};

  // One extra bit holds the carry on add and the borrow on subtract.
  assign w_s = w_m_stg.mode[MD_POST_SUB] ? ({1'b0, w_z} - w_madd)
                                         : ({1'b0, w_z} + w_madd);

  // Clamp to the rail in the direction of the overflow when saturation is on.
  always_comb begin
    w_p_next   = w_s[PW-1:0];
    w_ovf_next = w_s[PW];
    if (SAT_EN && w_s[PW]) begin
      if (w_m_stg.mode[MD_POST_SUB]) w_p_next = '0;
      else                           w_p_next = '1;
    end
  end

  // Result registers advance only on a valid operation with the clock enabled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_p         <= '0;
      r_carryout  <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (bus.CE) begin
      r_out_valid <= w_m_stg.valid;
      if (w_m_stg.valid) begin
        r_p        <= w_p_next;
        r_carryout <= w_s[PW];
        r_ovf      <= w_ovf_next;
      end
    end
  end

  assign bus.P         = r_p;
  assign bus.PCOUT     = r_p;
  assign bus.CARRYOUT  = r_carryout;
  assign bus.OVF       = r_ovf;
  assign bus.OUT_VALID = r_out_valid;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: two default-configured instances, one wrapping and
// one saturating, share the same stimulus. Directed steps check the called-out
// cases against constants; a scoreboard checks every result against an
// arithmetic reference model.
module tb_dsp_mac_pipe;

  localparam int AW = 18;
  localparam int BW = 18;
  localparam int PW = 48;
  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

  typedef struct packed {
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] d;
    logic [47:0] c;
    logic [4:0]  mode;
    logic        cin;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  dsp_mac_pipe_if #(.AW(AW), .BW(BW), .PW(PW)) bus0 ();
  dsp_mac_pipe_if #(.AW(AW), .BW(BW), .PW(PW)) bus1 ();

  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .IN_STAGES(2), .MREG(1), .SAT(0))
    u_wrap (.CLK(clk), .RST(rst), .bus(bus0));

  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .IN_STAGES(2), .MREG(1), .SAT(1))
    u_sat (.CLK(clk), .RST(rst), .bus(bus1));

  assign bus1.CE       = bus0.CE;
  assign bus1.IN_VALID = bus0.IN_VALID;
  assign bus1.A        = bus0.A;
  assign bus1.B        = bus0.B;
  assign bus1.D        = bus0.D;
  assign bus1.C        = bus0.C;
  assign bus1.PCIN     = bus0.PCIN;
  assign bus1.CARRYIN  = bus0.CARRYIN;
  assign bus1.MODE     = bus0.MODE;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("%s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: arithmetic straight from the operation's definition.
  task automatic ref_op(input op_t o, input logic [47:0] p_prev, input logic [47:0] pcin,
                        input bit sat, output logic [47:0] p, output logic co, output logic ovf);
    logic [17:0]     x;
    longint unsigned m, z, addend, full;
    x = o.b;
    if (o.mode[0]) x = o.mode[1] ? (o.d - o.b) : (o.d + o.b);
    m = x * o.a;
    case (o.mode[3:2])
      2'b00:   z = 0;
      2'b01:   z = o.c;
      2'b10:   z = pcin;
      default: z = p_prev;
    endcase
    addend = m + o.cin;
    if (!o.mode[4]) begin
      full = z + addend;
      ovf  = (full >= 64'h1_0000_0000_0000);
      p    = full[47:0];
      if (sat && ovf) p = ONES;
    end else begin
      ovf  = (z < addend);
      full = z - addend;
      p    = full[47:0];
      if (sat && ovf) p = '0;
    end
    co = ovf;
  endtask

  // Capture what the DUTs saw at each rising edge.
  logic cap_rst = 1'b0;
  logic cap_ce  = 1'b0;
  logic cap_v   = 1'b0;
  op_t  cap_op;

  always @(posedge clk) begin
    cap_rst <= rst;
    cap_ce  <= bus0.CE;
    cap_v   <= bus0.IN_VALID;
    cap_op  <= '{a: bus0.A, b: bus0.B, d: bus0.D, c: bus0.C, mode: bus0.MODE, cin: bus0.CARRYIN};
  end

  // Scoreboard: in-order queue of accepted operations, retired on each new result.
  op_t         q[$];
  logic [47:0] mp0 = '0;
  logic [47:0] mp1 = '0;

  always @(negedge clk) begin
    op_t         o;
    logic [47:0] e0, e1;
    logic        co0, co1, ov0, ov1;
    if (cap_rst) begin
      q.delete();
      mp0 = '0;
      mp1 = '0;
    end else begin
      if (cap_ce && bus0.OUT_VALID) begin
        check("mon_pending", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          o = q.pop_front();
          ref_op(o, mp0, bus0.PCIN, 1'b0, e0, co0, ov0);
          ref_op(o, mp1, bus0.PCIN, 1'b1, e1, co1, ov1);
          check("mon_p_wrap",   64'(bus0.P),        64'(e0));
          check("mon_pcout",    64'(bus0.PCOUT),    64'(e0));
          check("mon_co_wrap",  64'(bus0.CARRYOUT), 64'(co0));
          check("mon_ovf_wrap", 64'(bus0.OVF),      64'(ov0));
          check("mon_p_sat",    64'(bus1.P),        64'(e1));
          check("mon_ovf_sat",  64'(bus1.OVF),      64'(ov1));
          check("mon_vld_sat",  64'(bus1.OUT_VALID), 64'd1);
          mp0 = e0;
          mp1 = e1;
        end
      end
      if (cap_ce && cap_v) q.push_back(cap_op);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one operation for one enabled clock, then drop IN_VALID.
  task automatic drive_op(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                          input logic [47:0] c, input logic [4:0] mode, input logic cin);
    bus0.A = a; bus0.B = b; bus0.D = d; bus0.C = c;
    bus0.MODE = mode; bus0.CARRYIN = cin; bus0.IN_VALID = 1'b1;
    @(negedge clk);
    bus0.IN_VALID = 1'b0;
  endtask

  initial begin
    int ov_count;
    bus0.CE = 1'b1; bus0.IN_VALID = 1'b0;
    bus0.A = '0; bus0.B = '0; bus0.D = '0; bus0.C = '0;
    bus0.PCIN = '0; bus0.CARRYIN = 1'b0; bus0.MODE = '0;

    // Reset state
    rst = 1'b1;
    idle(2);
    check("rst_p",     64'(bus0.P),         64'd0);
    check("rst_m",     64'(bus0.M),         64'd0);
    check("rst_bcout", 64'(bus0.BCOUT),     64'd0);
    check("rst_vld",   64'(bus0.OUT_VALID), 64'd0);
    check("rst_co",    64'(bus0.CARRYOUT),  64'd0);
    check("rst_ovf",   64'(bus0.OVF),       64'd0);
    check("rst_p_sat", 64'(bus1.P),         64'd0);
    rst = 1'b0;
    idle(1);

    // Pre-add with latency: (5+4)*3 + 10 = 37 on the fourth edge
    drive_op(18'd3, 18'd4, 18'd5, 48'd10, 5'b00101, 1'b0);
    check("lat_e1", 64'(bus0.OUT_VALID), 64'd0);
    idle(1); check("lat_e2", 64'(bus0.OUT_VALID), 64'd0);
    idle(1); check("lat_e3", 64'(bus0.OUT_VALID), 64'd0);
    idle(1);
    check("lat_e4",   64'(bus0.OUT_VALID), 64'd1);
    check("preadd_p", 64'(bus0.P),         64'd37);
    check("preadd_co", 64'(bus0.CARRYOUT), 64'd0);
    idle(1); check("lat_e5", 64'(bus0.OUT_VALID), 64'd0);

    // Pre-subtract wraps modulo 2^18
    drive_op(18'd1, 18'd5, 18'd2, 48'd0, 5'b00011, 1'b0);
    idle(3);
    check("presub_p",     64'(bus0.P),     64'd262141);
    check("presub_m",     64'(bus0.M),     64'd262141);
    check("presub_bcout", 64'(bus0.BCOUT), 64'd5);

    // Reset with three operations in flight
    drive_op(18'd7, 18'd1, 18'd1, 48'd11, 5'b00101, 1'b0);
    drive_op(18'd8, 18'd2, 18'd1, 48'd12, 5'b00101, 1'b0);
    drive_op(18'd9, 18'd3, 18'd1, 48'd13, 5'b00101, 1'b0);
    rst = 1'b1;
    idle(2);
    check("midrst_p",   64'(bus0.P),         64'd0);
    check("midrst_vld", 64'(bus0.OUT_VALID), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("midrst_no_result", 64'(bus0.OUT_VALID), 64'd0);
    end

    // Accumulate valid / bubble / valid / valid from P=0
    drive_op(18'd2, 18'd3, 18'd0, 48'd0, 5'b01100, 1'b0);
    idle(1);
    drive_op(18'd2, 18'd3, 18'd0, 48'd0, 5'b01100, 1'b0);
    drive_op(18'd2, 18'd3, 18'd0, 48'd0, 5'b01100, 1'b0);
    check("acc_p1", 64'(bus0.P), 64'd6);
    idle(1);
    check("acc_hold",     64'(bus0.P),         64'd6);
    check("acc_hold_vld", 64'(bus0.OUT_VALID), 64'd0);
    idle(1); check("acc_p2", 64'(bus0.P), 64'd12);
    idle(1); check("acc_p3", 64'(bus0.P), 64'd18);

    // Add overflow: saturating vs wrapping
    drive_op(18'd1, 18'd1, 18'd0, ONES, 5'b00100, 1'b0);
    idle(3);
    check("satadd_p",    64'(bus1.P),        64'(ONES));
    check("satadd_co",   64'(bus1.CARRYOUT), 64'd1);
    check("satadd_ovf",  64'(bus1.OVF),      64'd1);
    check("wrapadd_p",   64'(bus0.P),        64'd0);
    check("wrapadd_ovf", 64'(bus0.OVF),      64'd1);

    // Subtract underflow: saturating vs wrapping
    drive_op(18'd1, 18'd1, 18'd0, 48'd0, 5'b10100, 1'b0);
    idle(3);
    check("satsub_p",    64'(bus1.P),        64'd0);
    check("satsub_co",   64'(bus1.CARRYOUT), 64'd1);
    check("satsub_ovf",  64'(bus1.OVF),      64'd1);
    check("wrapsub_p",   64'(bus0.P),        64'(ONES));
    check("wrapsub_ovf", 64'(bus0.OVF),      64'd1);

    // Clock-enable stall with two operations in flight
    drive_op(18'd5, 18'd6, 18'd0, 48'd100,  5'b00100, 1'b0);
    drive_op(18'd7, 18'd2, 18'd0, 48'd1000, 5'b00100, 1'b0);
    bus0.CE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("stall_vld", 64'(bus0.OUT_VALID), 64'd0);
      check("stall_p",   64'(bus0.P),         64'(ONES));
    end
    bus0.CE = 1'b1;
    ov_count = 0;
    for (int k = 0; k < 6; k++) begin
      idle(1);
      if (bus0.OUT_VALID) ov_count++;
      check("stall_vld_seq", 64'(bus0.OUT_VALID), 64'((k == 1) || (k == 2)));
      if (k == 1) check("stall_p1", 64'(bus0.P), 64'd130);
      if (k == 2) check("stall_p2", 64'(bus0.P), 64'd1014);
    end
    check("stall_pulses", 64'(ov_count), 64'd2);

    // Randomised traffic with random clock-enable gaps
    bus0.PCIN = 48'({$urandom(), $urandom()});
    for (int i = 0; i < 300; i++) begin
      bus0.CE       = ($urandom_range(0, 7) != 0);
      bus0.IN_VALID = ($urandom_range(0, 3) != 0);
      bus0.A        = 18'($urandom());
      bus0.B        = 18'($urandom());
      bus0.D        = 18'($urandom());
      bus0.C        = 48'({$urandom(), $urandom()});
      bus0.MODE     = 5'($urandom());
      bus0.CARRYIN  = 1'($urandom());
      @(negedge clk);
    end
    bus0.CE = 1'b1;
    bus0.IN_VALID = 1'b0;
    idle(10);
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
